// File: rtl/decode_stage.sv
// decode_stage: decodes RV64I OP-IMM and OP instructions into ALU operation
// codes, reads operands from a 32x64 register file with a writeback port,
// and holds the result in a single-entry valid/ready output slot.
module decode_stage #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int INSTR_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INSTR_WIDTH-1:0]    in_instr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [5:0]                alu_control,
    output logic [BUS_DATA_WIDTH-1:0] dataA,
    output logic [BUS_DATA_WIDTH-1:0] dataB,
    output logic [4:0]                rd,
    output logic                      rd_we,
    output logic                      illegal,
    input  logic                      flush,
    input  logic                      wb_en,
    input  logic [4:0]                wb_rd,
    input  logic [BUS_DATA_WIDTH-1:0] wb_data
);

    logic [BUS_DATA_WIDTH-1:0] regFile [32];

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1Addr;
    logic [4:0] rs2Addr;
    logic [4:0] rdAddr;

    logic [BUS_DATA_WIDTH-1:0] rs1Val;
    logic [BUS_DATA_WIDTH-1:0] rs2Val;
    logic [BUS_DATA_WIDTH-1:0] immSext;
    logic [BUS_DATA_WIDTH-1:0] shamtZext;
    logic [BUS_DATA_WIDTH-1:0] decDataB;
    logic [5:0]                decAlu;
    logic                      decIllegal;

    logic outValid;
    logic accept;
    logic wbWrite;

    assign opcode  = in_instr[6:0];
    assign rdAddr  = in_instr[11:7];
    assign funct3  = in_instr[14:12];
    assign rs1Addr = in_instr[19:15];
    assign rs2Addr = in_instr[24:20];
    assign funct7  = in_instr[31:25];

    assign immSext   = {{(BUS_DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
    assign shamtZext = {{(BUS_DATA_WIDTH-6){1'b0}}, in_instr[25:20]};

    assign wbWrite  = wb_en && (wb_rd != 5'd0);
    assign in_ready = !outValid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign out_valid = outValid;

    // Operand read: x0 is hard-wired to zero, and a same-cycle writeback
    // to the source register is forwarded so the slot never holds stale data.
    always_comb begin
        rs1Val = regFile[rs1Addr];
        rs2Val = regFile[rs2Addr];
        if (rs1Addr == 5'd0) begin
            rs1Val = '0;
        end else if (wbWrite && (wb_rd == rs1Addr)) begin
            rs1Val = wb_data;
        end
        if (rs2Addr == 5'd0) begin
            rs2Val = '0;
        end else if (wbWrite && (wb_rd == rs2Addr)) begin
            rs2Val = wb_data;
        end
    end

    // Instruction decode: anything outside the supported OP-IMM/OP encodings
    // (including bad funct7/funct6 on shifts) is flagged illegal with code 0.
    always_comb begin
        decAlu     = 6'b000000;
        decIllegal = 1'b0;
        decDataB   = rs2Val;
        case (opcode)
            7'b0010011: begin
                decDataB = immSext;
                case (funct3)
                    3'b000: decAlu = 6'b000001;
                    3'b010: decAlu = 6'b000010;
                    3'b011: decAlu = 6'b000011;
                    3'b100: decAlu = 6'b000100;
                    3'b110: decAlu = 6'b000101;
                    3'b111: decAlu = 6'b000110;
                    3'b001: begin
                        decDataB = shamtZext;
                        if (in_instr[31:26] == 6'b000000) decAlu = 6'b000111;
                        else                              decIllegal = 1'b1;
                    end
                    default: begin
                        decDataB = shamtZext;
                        if (in_instr[31:26] == 6'b000000)      decAlu = 6'b001000;
                        else if (in_instr[31:26] == 6'b010000) decAlu = 6'b001001;
                        else                                   decIllegal = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  decAlu = 6'b001100;
                        3'b001:  decAlu = 6'b001110;
                        3'b010:  decAlu = 6'b001111;
                        3'b011:  decAlu = 6'b010000;
                        3'b100:  decAlu = 6'b010001;
                        3'b101:  decAlu = 6'b010010;
                        3'b110:  decAlu = 6'b010100;
                        default: decAlu = 6'b010101;
                    endcase
                end else if ((funct7 == 7'b0100000) && (funct3 == 3'b000)) begin
                    decAlu = 6'b001101;
                end else if ((funct7 == 7'b0100000) && (funct3 == 3'b101)) begin
                    decAlu = 6'b010011;
                end else begin
                    decIllegal = 1'b1;
                end
            end
            default: decIllegal = 1'b1;
        endcase
    end

    // Register file writeback runs regardless of slot state; x0 is never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regFile[i] <= '0;
            end
        end else if (wbWrite) begin
            regFile[wb_rd] <= wb_data;
        end
    end

    // Output slot: flush wins, then a new accept replaces the slot, otherwise
    // a drain empties it and a stall holds it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid    <= 1'b0;
            alu_control <= '0;
            dataA       <= '0;
            dataB       <= '0;
            rd          <= '0;
            rd_we       <= 1'b0;
            illegal     <= 1'b0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (accept) begin
            outValid    <= 1'b1;
            alu_control <= decAlu;
            dataA       <= rs1Val;
            dataB       <= decDataB;
            rd          <= rdAddr;
            rd_we       <= !decIllegal && (rdAddr != 5'd0);
            illegal     <= decIllegal;
        end else if (out_ready) begin
            outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized stimulus for decode_stage, checked
// against a behavioural model of the slot, register file and decode tables.
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  alu_control;
    logic [63:0] dataA;
    logic [63:0] dataB;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model state
    logic [63:0] refRegs [32];
    logic        expValid;
    logic [5:0]  expAlu;
    logic [63:0] expDataA;
    logic [63:0] expDataB;
    logic [4:0]  expRd;
    logic        expRdWe;
    logic        expIllegal;

    // ALU codes indexed by funct3 (base code; alternate forms add one)
    int opImmCode [8] = '{1, 7, 2, 3, 4, 8, 5, 6};
    int opRegCode [8] = '{12, 14, 15, 16, 17, 18, 20, 21};

    decode_stage #(.BUS_DATA_WIDTH(64), .INSTR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .dataA(dataA), .dataB(dataB),
        .rd(rd), .rd_we(rd_we), .illegal(illegal), .flush(flush),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic void modelDecode(input logic [31:0] ins, input logic [63:0] rs2v,
                                        output logic [5:0] alu, output logic ill, output logic [63:0] opB);
        logic [2:0] f3;
        logic [6:0] f7;
        logic       alt;
        f3  = ins[14:12];
        f7  = ins[31:25];
        alu = 6'd0;
        ill = 1'b1;
        opB = rs2v;
        if (ins[6:0] == 7'h13) begin
            alt = ins[30];
            if (f3 == 3'd1)      ill = (ins[31:26] != 6'h00);
            else if (f3 == 3'd5) ill = !((ins[31:26] == 6'h00) || (ins[31:26] == 6'h10));
            else                 ill = 1'b0;
            alu = 6'(opImmCode[f3] + ((f3 == 3'd5 && alt) ? 1 : 0));
            if (f3 == 3'd1 || f3 == 3'd5) opB = {58'd0, ins[25:20]};
            else                          opB = 64'($signed(ins[31:20]));
        end else if (ins[6:0] == 7'h33) begin
            alt = (f7 == 7'h20);
            ill = !((f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5)));
            alu = 6'(opRegCode[f3] + (alt ? 1 : 0));
        end
        if (ill) alu = 6'd0;
    endfunction

    task automatic resetModel();
        expValid = 1'b0;
        for (int i = 0; i < 32; i++) refRegs[i] = 64'd0;
    endtask

    task automatic checkSlot();
        checkOutput("out_valid", {63'd0, out_valid}, {63'd0, expValid});
        if (expValid) begin
            checkOutput("illegal", {63'd0, illegal}, {63'd0, expIllegal});
            checkOutput("alu_control", {58'd0, alu_control}, {58'd0, expAlu});
            checkOutput("rd_we", {63'd0, rd_we}, {63'd0, expRdWe});
            if (!expIllegal) begin
                checkOutput("rd", {59'd0, rd}, {59'd0, expRd});
                checkOutput("dataA", dataA, expDataA);
                checkOutput("dataB", dataB, expDataB);
            end
        end
    endtask

    // One clock cycle: drive at negedge, check in_ready, advance the model
    // at posedge, then check the output slot shortly after.
    task automatic applyStimulus(input logic iv, input logic [31:0] ins, input logic ordy,
                                 input logic fl, input logic we, input logic [4:0] wrd,
                                 input logic [63:0] wdat);
        logic        acc;
        logic [63:0] a;
        logic [63:0] b;
        logic [5:0]  alu;
        logic        ill;
        logic [63:0] opB;
        @(negedge clk);
        in_valid  = iv;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        wb_en     = we;
        wb_rd     = wrd;
        wb_data   = wdat;
        #1;
        checkOutput("in_ready", {63'd0, in_ready}, {63'd0, (!expValid || ordy)});
        @(posedge clk);
        acc = iv && (!expValid || ordy) && !fl;
        if (acc) begin
            a = (we && wrd != 0 && wrd == ins[19:15]) ? wdat : refRegs[ins[19:15]];
            b = (we && wrd != 0 && wrd == ins[24:20]) ? wdat : refRegs[ins[24:20]];
            if (ins[19:15] == 0) a = 64'd0;
            if (ins[24:20] == 0) b = 64'd0;
            modelDecode(ins, b, alu, ill, opB);
            expAlu     = alu;
            expIllegal = ill;
            expDataA   = a;
            expDataB   = opB;
            expRd      = ins[11:7];
            expRdWe    = !ill && (ins[11:7] != 0);
        end
        if (fl)        expValid = 1'b0;
        else if (acc)  expValid = 1'b1;
        else if (ordy) expValid = 1'b0;
        if (we && wrd != 0) refRegs[wrd] = wdat;
        #1;
        checkSlot();
    endtask

    function automatic logic [31:0] randomInstr();
        int          kind;
        int          sel;
        logic [6:0]  upper;
        logic [6:0]  opc;
        kind = $urandom_range(0, 9);
        sel  = $urandom_range(0, 3);
        if (sel == 1)      upper = 7'h20;
        else if (sel == 2) upper = 7'($urandom);
        else               upper = 7'h00;
        if (kind < 4)      opc = 7'h13;
        else if (kind < 8) opc = 7'h33;
        else               opc = 7'($urandom);
        return {upper, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                3'($urandom), 5'($urandom_range(0, 7)), opc};
    endfunction

    initial begin
        reset = 1'b1; in_valid = 0; in_instr = 0; out_ready = 0;
        flush = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        checkSlot();
        checkOutput("rst_alu", {58'd0, alu_control}, 64'd0);
        checkOutput("rst_dataA", dataA, 64'd0);
        checkOutput("rst_dataB", dataB, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // x0 writes are ignored; addi x1,x0,5
        applyStimulus(0, 32'h0, 1, 0, 1, 5'd0, 64'h0);
        applyStimulus(0, 32'h0, 1, 0, 1, 5'd0, 64'hDEAD);
        applyStimulus(1, 32'h00500093, 1, 0, 0, 5'd0, 64'h0);
        checkOutput("addi_alu", {58'd0, alu_control}, 64'b000001);
        checkOutput("addi_dataA", dataA, 64'd0);
        checkOutput("addi_dataB", dataB, 64'd5);
        checkOutput("addi_rd", {59'd0, rd}, 64'd1);
        checkOutput("addi_rd_we", {63'd0, rd_we}, 64'd1);

        // sub x3,x1,x2 and addi x2,x0,-1
        applyStimulus(0, 32'h0, 1, 0, 1, 5'd1, 64'd7);
        applyStimulus(0, 32'h0, 1, 0, 1, 5'd2, 64'd3);
        applyStimulus(1, 32'h402081B3, 1, 0, 0, 5'd0, 64'h0);
        checkOutput("sub_alu", {58'd0, alu_control}, 64'b001101);
        checkOutput("sub_dataA", dataA, 64'd7);
        checkOutput("sub_dataB", dataB, 64'd3);
        applyStimulus(1, 32'hFFF00113, 1, 0, 0, 5'd0, 64'h0);
        checkOutput("neg_imm", dataB, 64'hFFFF_FFFF_FFFF_FFFF);

        // srai x5,x6,3 with same-cycle writeback bypass on x6
        applyStimulus(0, 32'h0, 1, 0, 1, 5'd6, 64'h80);
        applyStimulus(1, 32'h40335293, 1, 0, 1, 5'd6, 64'h100);
        checkOutput("srai_alu", {58'd0, alu_control}, 64'b001001);
        checkOutput("srai_dataA", dataA, 64'h100);
        checkOutput("srai_dataB", dataB, 64'd3);

        // add x7,x1,x2 then stall three cycles, then back-to-back accepts
        applyStimulus(1, 32'h002083B3, 1, 0, 0, 5'd0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h00500093, 0, 0, 0, 5'd0, 64'h0);
            checkOutput("stall_alu", {58'd0, alu_control}, 64'b001100);
            checkOutput("stall_dataA", dataA, 64'd7);
        end
        applyStimulus(1, 32'h00500093, 1, 0, 0, 5'd0, 64'h0);
        checkOutput("b2b_alu0", {58'd0, alu_control}, 64'b000001);
        applyStimulus(1, 32'h402081B3, 1, 0, 0, 5'd0, 64'h0);
        checkOutput("b2b_alu1", {58'd0, alu_control}, 64'b001101);
        applyStimulus(1, 32'h002083B3, 1, 0, 0, 5'd0, 64'h0);
        checkOutput("b2b_valid", {63'd0, out_valid}, 64'd1);

        // unsupported load opcode, then flush with a full slot
        applyStimulus(1, 32'h00003083, 1, 0, 0, 5'd0, 64'h0);
        checkOutput("ill_flag", {63'd0, illegal}, 64'd1);
        checkOutput("ill_alu", {58'd0, alu_control}, 64'd0);
        checkOutput("ill_rd_we", {63'd0, rd_we}, 64'd0);
        applyStimulus(1, 32'h00500093, 0, 1, 0, 5'd0, 64'h0);
        checkOutput("flush_valid", {63'd0, out_valid}, 64'd0);

        // asynchronous reset while stalled
        applyStimulus(0, 32'h0, 1, 0, 1, 5'd1, 64'hAB);
        applyStimulus(1, 32'h402081B3, 1, 0, 0, 5'd0, 64'h0);
        applyStimulus(1, 32'h00500093, 0, 0, 0, 5'd0, 64'h0);
        @(negedge clk);
        in_valid = 0; out_ready = 0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("areset_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("areset_alu", {58'd0, alu_control}, 64'd0);
        checkOutput("areset_dataA", dataA, 64'd0);
        resetModel();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1, 32'h00008113, 1, 0, 0, 5'd0, 64'h0);
        checkOutput("areset_x1", dataA, 64'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 8), randomInstr(),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                          1'($urandom), 5'($urandom_range(0, 7)),
                          {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode stage directly upstream of the execute ALU.
- Accepts one 32-bit RV64I instruction per handshake from fetch and decodes OP-IMM and OP instructions into the 6-bit ALU operation code.
- Reads rs1/rs2 from an internal 32x64 register file with a writeback port, and sign-extends immediates.
- Presents dataA/dataB/alu_control in a single-entry registered output slot with valid/ready flow control.

Parameters:
BUS_DATA_WIDTH, 64, operand/register width
INSTR_WIDTH, 32, instruction width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-high reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  decode can accept this cycle
in_instr  in  INSTR_WIDTH  instruction word
out_valid  out  1  output slot holds a decoded op
out_ready  in  1  execute accepts output slot
alu_control  out  6  ALU operation code
dataA  out  BUS_DATA_WIDTH  rs1 value
dataB  out  BUS_DATA_WIDTH  rs2 value or sign-extended immediate
rd  out  5  destination register
rd_we  out  1  destination write enable (0 for illegal or rd==0)
illegal  out  1  unsupported instruction
flush  in  1  discard slot and incoming instruction
wb_en  in  1  register file write enable
wb_rd  in  5  write address
wb_data  in  BUS_DATA_WIDTH  write data

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: out_valid=0, alu_control=0, dataA=0, dataB=0, rd=0, rd_we=0, illegal=0, all 32 registers=0. Reset mid-operation drops the held instruction immediately.
- Accept condition: in_ready = !out_valid || out_ready (combinational). An accept is in_valid && in_ready && !flush.
- Latency: an accepted instruction appears on the outputs the next cycle with out_valid=1.
- Hold: the output slot is stable while out_valid && !out_ready.
- Slot clear: out_valid falls when the slot drains with no new accept.
- flush: has priority. Next cycle out_valid=0 and the incoming instruction is dropped.
- Opcode 0010011 (OP-IMM), by funct3:
  - 000 addi=000001
  - 010 slti=000010
  - 011 sltiu=000011
  - 100 xori=000100
  - 110 ori=000101
  - 111 andi=000110
  - 001 slli=000111
  - 101 srli=001000 when instr[30]=0, srai=001001 when instr[30]=1
  - dataB = sign-extended instr[31:20]; for shifts dataB = zero-extended instr[25:20].
- Opcode 0110011 (OP), by funct3 and instr[30]:
  - 000/0 add=001100, 000/1 sub=001101
  - 001 sll=001110
  - 010 slt=001111
  - 011 sltu=010000
  - 100 xor=010001
  - 101/0 srl=010010, 101/1 sra=010011
  - 110 or=010100
  - 111 and=010101
  - dataB = rs2 value.
- Illegal: any other opcode, or funct7 not in {0000000, 0100000 where permitted}, gives illegal=1, alu_control=000000, rd_we=0. The slot still handshakes normally.
- Register file reads are combinational at accept time. x0 always reads 0.
- Register file writes happen on the clock edge when wb_en && wb_rd!=0; writes to x0 are ignored.
- Bypass: on a same-cycle wb write to rs1/rs2 (nonzero), the decoded operand takes wb_data.
- Writeback is independent of handshake state and is accepted during stall and flush.
- Simultaneous drain and accept: the slot is replaced seamlessly with no bubble.

Test Plan:
- reset asserted asynchronously mid-stall -> out_valid=0, alu_control=0, and x1 reads 0 afterwards.
- wb x0<-0; send 0x00500093 (addi x1,x0,5) with out_ready=1 -> next cycle alu_control=000001, dataA=0, dataB=5, rd=1, rd_we=1.
- Preload x1=7, x2=3; send 0x402081B3 (sub x3,x1,x2) -> alu_control=001101, dataA=7, dataB=3. Send 0xFFF00113 -> dataB=0xFFFF_FFFF_FFFF_FFFF.
- x6=0x80; send 0x40335293 (srai x5,x6,3) while wb_en writes x6=0x100 the same cycle -> alu_control=001001, dataA=0x100, dataB=3.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs unchanged. Release -> back-to-back instructions at 1 per cycle with no bubble.
- Send opcode 0000011 -> illegal=1, alu_control=0, rd_we=0. Assert flush with out_valid=1 -> next cycle out_valid=0 and the incoming instruction is dropped.
